// File: rtl/fetch_queue.sv
// Dual-lane circular instruction buffer sitting between fetch and decode.
// Accepts up to two packets per cycle and presents the two oldest in program order.
module fetch_queue #(
   parameter int DEPTH         = 8,
   parameter int DW            = 64,
   parameter int MACHINE_WIDTH = 2
) (
   input  logic                          i_clk,
   input  logic                          i_resetn,
   input  logic                          i_flush,
   input  logic [MACHINE_WIDTH-1:0]      i_in_valid,
   input  logic [MACHINE_WIDTH*DW-1:0]   i_in_data,
   output logic                          o_in_ready,
   output logic [MACHINE_WIDTH-1:0]      o_out_valid,
   output logic [MACHINE_WIDTH*DW-1:0]   o_out_data,
   input  logic                          i_out_ready,
   output logic [$clog2(DEPTH):0]        o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [DW-1:0] r_mem [DEPTH];

   logic [CW-1:0] w_free;
   logic          w_inReady;
   logic [1:0]    w_outValid;
   logic [1:0]    w_enqN;
   logic [1:0]    w_deqN;
   logic [AW-1:0] w_headPlus1;
   logic [AW-1:0] w_tailPlus1;

   // in_ready looks only at the registered count, so a pair never splits across a stall
   always_comb begin
      w_free      = CW'(DEPTH) - r_count;
      w_inReady   = (w_free >= CW'(2));
      w_outValid  = 2'b00;
      w_enqN      = 2'd0;
      w_deqN      = 2'd0;
      w_headPlus1 = r_head + AW'(1);
      w_tailPlus1 = r_tail + AW'(1);
      if (!i_flush) begin
         w_outValid = {(r_count >= CW'(2)), (r_count >= CW'(1))};
      end
      if (w_inReady) begin
         w_enqN = {1'b0, i_in_valid[0]} + {1'b0, i_in_valid[1]};
      end
      if (i_out_ready) begin
         w_deqN = {1'b0, w_outValid[0]} + {1'b0, w_outValid[1]};
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_resetn || i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + AW'(w_deqN);
         r_tail  <= r_tail + AW'(w_enqN);
         r_count <= r_count + CW'(w_enqN) - CW'(w_deqN);
      end
   end

   // Storage is deliberately not reset; occupancy alone decides what is visible
   always_ff @(posedge i_clk) begin
      if (i_resetn && !i_flush) begin
         if (w_enqN != 2'd0) begin
            r_mem[r_tail] <= i_in_data[DW-1:0];
         end
         if (w_enqN == 2'd2) begin
            r_mem[w_tailPlus1] <= i_in_data[2*DW-1:DW];
         end
      end
   end

   assign o_in_ready  = w_inReady;
   assign o_out_valid = w_outValid;
   assign o_out_data  = {r_mem[w_headPlus1], r_mem[r_head]};
   assign o_count     = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based model checked every cycle,
// plus directed scenarios with hand-computed pc expectations.
module tb_fetch_queue;

   localparam int DEPTH = 8;
   localparam int DW    = 64;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic            flush = 1'b0;
   logic            outReady = 1'b0;
   logic [1:0]      inValid = 2'b00;
   logic [2*DW-1:0] inData = '0;
   logic            inReady;
   logic [1:0]      outValid;
   logic [2*DW-1:0] outData;
   logic [3:0]      count;

   int testsRun = 0;
   int testsFailed = 0;

   logic [DW-1:0] modelQ[$];
   bit            resetSeen = 0;

   fetch_queue #(.DEPTH(DEPTH), .DW(DW), .MACHINE_WIDTH(2)) dut (
      .i_clk(clk),
      .i_resetn(resetn),
      .i_flush(flush),
      .i_in_valid(inValid),
      .i_in_data(inData),
      .o_in_ready(inReady),
      .o_out_valid(outValid),
      .o_out_data(outData),
      .i_out_ready(outReady),
      .o_count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mkPacket(input logic [31:0] pc);
      return {pc ^ 32'hA5A5_0000, pc};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rn, input logic fl, input logic [1:0] v,
                                input logic [31:0] pc, input logic ordy);
      resetn   = rn;
      flush    = fl;
      inValid  = v;
      inData   = {mkPacket(pc + 32'd4), mkPacket(pc)};
      outReady = ordy;
      @(posedge clk);
      #1;
   endtask

   // Model: a plain FIFO of packets, updated from the inputs present at each rising edge
   always @(posedge clk) begin
      int  deqN;
      bit  accept;
      if (!resetn) begin
         modelQ.delete();
         resetSeen = 1;
      end else if (flush) begin
         modelQ.delete();
      end else if (resetSeen) begin
         accept = (DEPTH - modelQ.size()) >= 2;
         deqN   = outReady ? ((modelQ.size() >= 2) ? 2 : modelQ.size()) : 0;
         repeat (deqN) void'(modelQ.pop_front());
         if (accept && inValid[0]) modelQ.push_back(inData[DW-1:0]);
         if (accept && inValid[1]) modelQ.push_back(inData[2*DW-1:DW]);
      end
   end

   // Compare process: outputs checked mid-cycle against the model
   always @(negedge clk) begin
      int         sz;
      logic [1:0] expValid;
      if (resetSeen) begin
         sz       = modelQ.size();
         expValid = flush ? 2'b00 : {(sz >= 2), (sz >= 1)};
         checkOutput("count", 64'(count), 64'(sz));
         checkOutput("in_ready", 64'(inReady), 64'((DEPTH - sz) >= 2));
         checkOutput("out_valid", 64'(outValid), 64'(expValid));
         if (expValid[0]) checkOutput("lane0_data", outData[DW-1:0], modelQ[0]);
         if (expValid[1]) checkOutput("lane1_data", outData[2*DW-1:DW], modelQ[1]);
         checkOutput("lane_order", 64'(inValid == 2'b10), 64'd0);
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset then idle
      applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
      checkOutput("idle_count", 64'(count), 64'd0);
      checkOutput("idle_in_ready", 64'(inReady), 64'd1);
      checkOutput("idle_out_valid", 64'(outValid), 64'd0);

      // Fill to full without draining
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 2'b11, 32'h1000 + 32'(i * 8), 1'b0);
         checkOutput("fill_count", 64'(count), 64'(2 * (i + 1)));
      end
      checkOutput("full_in_ready", 64'(inReady), 64'd0);
      applyStimulus(1'b1, 1'b0, 2'b11, 32'h1020, 1'b0);
      checkOutput("full_push_ignored", 64'(count), 64'd8);

      // Drain in program order
      for (int i = 0; i < 4; i++) begin
         checkOutput("drain_lane0_pc", 64'(outData[31:0]), 64'(32'h1000 + 32'(i * 8)));
         checkOutput("drain_lane1_pc", 64'(outData[DW+31:DW]), 64'(32'h1004 + 32'(i * 8)));
         applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 1'b1);
         checkOutput("drain_count", 64'(count), 64'(6 - 2 * i));
      end
      checkOutput("drained_out_valid", 64'(outValid), 64'd0);

      // Single lane, then pairs streaming through the wrap point
      applyStimulus(1'b1, 1'b0, 2'b01, 32'h2000, 1'b0);
      checkOutput("single_count", 64'(count), 64'd1);
      checkOutput("single_out_valid", 64'(outValid), 64'd1);
      checkOutput("single_pc", 64'(outData[31:0]), 64'h2000);
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 1'b1);
      checkOutput("single_popped", 64'(count), 64'd0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 1'b0, 2'b11, 32'h2004 + 32'(i * 8), 1'b1);
      end
      checkOutput("stream_count", 64'(count), 64'd2);
      checkOutput("stream_tail_pc", 64'(outData[31:0]), 64'h209C);

      // Simultaneous enqueue and dequeue at count 3
      applyStimulus(1'b1, 1'b0, 2'b01, 32'h3000, 1'b0);
      checkOutput("three_count", 64'(count), 64'd3);
      applyStimulus(1'b1, 1'b0, 2'b11, 32'h3100, 1'b1);
      checkOutput("simul_count", 64'(count), 64'd3);
      checkOutput("simul_lane0_pc", 64'(outData[31:0]), 64'h3000);
      checkOutput("simul_lane1_pc", 64'(outData[DW+31:DW]), 64'h3100);

      // Flush with traffic at count 5
      applyStimulus(1'b1, 1'b0, 2'b11, 32'h3200, 1'b0);
      checkOutput("five_count", 64'(count), 64'd5);
      resetn   = 1'b1;
      flush    = 1'b1;
      inValid  = 2'b11;
      inData   = {mkPacket(32'h4004), mkPacket(32'h4000)};
      outReady = 1'b1;
      #2;
      checkOutput("flush_out_valid", 64'(outValid), 64'd0);
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
      checkOutput("post_flush_count", 64'(count), 64'd0);
      checkOutput("post_flush_in_ready", 64'(inReady), 64'd1);
      checkOutput("post_flush_out_valid", 64'(outValid), 64'd0);
      applyStimulus(1'b1, 1'b0, 2'b11, 32'h5000, 1'b0);
      checkOutput("refill_lane0_pc", 64'(outData[31:0]), 64'h5000);
      checkOutput("refill_lane1_pc", 64'(outData[DW+31:DW]), 64'h5004);

      // Reset mid-operation behaves like a flush
      applyStimulus(1'b1, 1'b0, 2'b11, 32'h6000, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'b11, 32'h7000, 1'b1);
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
      checkOutput("midreset_count", 64'(count), 64'd0);
      checkOutput("midreset_out_valid", 64'(outValid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
